// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg -- shared types and constants for the run controller.
//
// Contents:
//   CNT_W        width of every counter in the controller (32 bits)
//   state_e      FSM state encoding (also exported on the debug port)
//   fail_code_e  reason code reported on fail_code
//   verdict_*    helpers that map a latched DUT verdict to the terminal
//                state and fail code
package run_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_RUN      = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_PASS     = 3'd3,
    ST_FAIL     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_DUT     = 2'd1,
    FC_TIMEOUT = 2'd2,
    FC_STALL   = 2'd3
  } fail_code_e;

  function automatic state_e verdict_state(input logic dut_ok);
    return dut_ok ? ST_PASS : ST_FAIL;
  endfunction

  function automatic fail_code_e verdict_code(input logic dut_ok);
    return dut_ok ? FC_NONE : FC_DUT;
  endfunction

endpackage

// File: rtl/run_ctr.sv
// run_ctr -- clearable, enabled, saturating up-counter.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset, forces count to 0
//   clr    synchronous clear to 0 (has priority over en)
//   en     count enable; the count sticks at all-ones instead of wrapping
//   count  current count value
module run_ctr
  import run_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_inc;

  assign count_inc = (count == '1) ? count : count + W'(1);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl -- simulation run controller.
//
// Holds the DUT in reset, then supervises the run phase until the DUT
// reports completion, the cycle budget runs out, or the DUT stops making
// progress. After completion a short drain window elapses before the
// final, sticky verdict.
//
// Ports:
//   ck         clock, rising edge
//   rst        asynchronous active-low reset
//   dut_rst    synchronous active-high reset to the DUT
//   dut_done   DUT completion strobe (only looked at in RUN)
//   dut_pass   DUT verdict, valid with dut_done
//   progress   heartbeat; restarts the stall count
//   cycle_cnt  RUN + DRAIN cycles, saturating
//   finish     sticky end-of-run flag
//   pass       sticky verdict, meaningful when finish=1
//   fail_code  NONE / DUT / TIMEOUT / STALL
//   state      current FSM state (debug)
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int STALL_CYCLES   = 1000,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic        ck,
  input  logic        rst,
  output logic        dut_rst,
  input  logic        dut_done,
  input  logic        dut_pass,
  input  logic        progress,
  output logic [31:0] cycle_cnt,
  output logic        finish,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [2:0]  state
);

  // Counters hold the number of cycles already completed, so each phase
  // ends when its counter shows "limit - 1" in the current cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  fail_code_e       fc_q, fc_d;
  logic             pass_q, pass_d;
  logic             finish_q;
  logic             dut_rst_q;

  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             in_run;
  logic             phase_clr, phase_en;
  logic             cyc_en;
  logic             stall_clr;
  logic             timeout_hit, stall_hit;

  assign in_run    = (state_q == ST_RUN);

  // One phase counter is shared by RST_HOLD and DRAIN; it restarts on
  // every state change so each phase measures from zero.
  assign phase_en  = (state_q == ST_RST_HOLD) || (state_q == ST_DRAIN);
  assign phase_clr = (state_d != state_q);
  assign cyc_en    = in_run || (state_q == ST_DRAIN);
  assign stall_clr = in_run && progress;

  run_ctr #(.W(CNT_W)) u_phase_ctr (
    .clk   (ck),
    .rst_n (rst),
    .clr   (phase_clr),
    .en    (phase_en),
    .count (phase_cnt)
  );

  run_ctr #(.W(CNT_W)) u_cycle_ctr (
    .clk   (ck),
    .rst_n (rst),
    .clr   (1'b0),
    .en    (cyc_en),
    .count (cycle_cnt)
  );

  run_ctr #(.W(CNT_W)) u_stall_ctr (
    .clk   (ck),
    .rst_n (rst),
    .clr   (stall_clr),
    .en    (in_run),
    .count (stall_cnt)
  );

  // A progress pulse in the same cycle zeroes the count, so it can never
  // complete a stall.
  assign timeout_hit = (cycle_cnt == TIMEOUT_LAST);
  assign stall_hit   = (STALL_CYCLES != 0) && !progress && (stall_cnt == STALL_LAST);

  // NOTE: every always_comb output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_RST_HOLD: begin
        if (phase_cnt == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Priority: completion beats timeout beats stall.
        if (dut_done) begin
          pass_d = dut_pass;
          if (DRAIN_CYCLES == 0) begin
            state_d = verdict_state(dut_pass);
            fc_d    = verdict_code(dut_pass);
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (timeout_hit) begin
          state_d = ST_FAIL;
          fc_d    = FC_TIMEOUT;
        end else if (stall_hit) begin
          state_d = ST_FAIL;
          fc_d    = FC_STALL;
        end
      end
      ST_DRAIN: begin
        if (phase_cnt == DRAIN_LAST) begin
          state_d = verdict_state(pass_q);
          fc_d    = verdict_code(pass_q);
        end
      end
      ST_PASS, ST_FAIL: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_RST_HOLD;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RST_HOLD;
      fc_q      <= FC_NONE;
      pass_q    <= 1'b0;
      finish_q  <= 1'b0;
      dut_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      pass_q    <= pass_d;
      finish_q  <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      // Registered so the DUT sees a clean reset aligned with RUN entry.
      dut_rst_q <= (state_d == ST_RST_HOLD);
    end
  end

  assign dut_rst   = dut_rst_q;
  assign finish    = finish_q;
  assign pass      = pass_q;
  assign fail_code = fc_q;
  assign state     = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- self-checking bench for run_ctrl.
//
// Each scenario resets the controller, measures the dut_rst hold, then
// walks the run phase one cycle at a time. A reference model built from
// the run rules (cycle budget, stall window, completion priority, drain
// length) predicts the outcome, final count and verdict.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int RST_C = 4;
  localparam int TO_C  = 100;
  localparam int ST_C  = 10;
  localparam int DR_C  = 3;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        dut_done = 1'b0;
  logic        dut_pass = 1'b0;
  logic        progress = 1'b0;
  logic        dut_rst;
  logic [31:0] cycle_cnt;
  logic        finish;
  logic        pass;
  logic [1:0]  fail_code;
  logic [2:0]  state;

  int    checks = 0;
  int    errors = 0;
  string scn = "";

  run_ctrl #(
    .RST_CYCLES     (RST_C),
    .TIMEOUT_CYCLES (TO_C),
    .STALL_CYCLES   (ST_C),
    .DRAIN_CYCLES   (DR_C)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .dut_rst   (dut_rst),
    .dut_done  (dut_done),
    .dut_pass  (dut_pass),
    .progress  (progress),
    .cycle_cnt (cycle_cnt),
    .finish    (finish),
    .pass      (pass),
    .fail_code (fail_code),
    .state     (state)
  );

  always #5 ck = ~ck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", scn, tag, got, exp);
    end
  endtask

  task automatic drive_noise();
    dut_done = 1'($urandom);
    dut_pass = 1'($urandom);
    progress = 1'($urandom);
  endtask

  task automatic check_reset_outputs();
    check("rst_dut_rst", 32'(dut_rst), 32'd1);
    check("rst_cnt", cycle_cnt, 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fc", 32'(fail_code), 32'd0);
    check("rst_state", 32'(state), 32'(ST_RST_HOLD));
  endtask

  // prog_kind: 0 random with arg% probability, 1 every arg cycles,
  // 2 only at run cycle arg, 3 every 10 cycles up to cycle arg
  function automatic bit prog_at(input int kind, input int arg, input int r);
    case (kind)
      0:       return ($urandom_range(0, 99) < arg);
      1:       return (r % arg) == (arg - 1);
      2:       return r == arg;
      default: return ((r % 10) == 9) && (r <= arg);
    endcase
  endfunction

  task automatic run_scn(input string name, input int done_at, input bit pass_val,
                         input int prog_kind, input int prog_arg, input bit abort_drain);
    int r, stall, outcome, hold, exp_cnt, exp_fc;
    bit p, d, exp_pass;
    scn = name;

    // Reset takes effect immediately, without a clock edge.
    dut_done = 1'b0;
    progress = 1'b0;
    dut_pass = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge ck);
    rst = 1'b1;

    hold = 0;
    while (dut_rst === 1'b1 && hold < RST_C + 10) begin
      hold++;
      drive_noise();
      @(negedge ck);
    end
    check("rst_hold_len", 32'(hold), 32'(RST_C));

    // Model: completion first, then budget, then stall window.
    r = 0;
    stall = 0;
    outcome = 0;
    while (outcome == 0 && r < 1000) begin
      check("run_cnt", cycle_cnt, 32'(r));
      check("run_finish", 32'(finish), 32'd0);
      check("run_dut_rst", 32'(dut_rst), 32'd0);
      p = prog_at(prog_kind, prog_arg, r);
      d = (r == done_at);
      progress = p;
      dut_done = d;
      dut_pass = d ? pass_val : 1'($urandom);
      stall = p ? 0 : stall + 1;
      if (d)                            outcome = 1;
      else if (r + 1 == TO_C)           outcome = 2;
      else if (ST_C > 0 && stall == ST_C) outcome = 3;
      r++;
      @(negedge ck);
    end

    exp_cnt = r;
    if (outcome == 1) begin
      for (int i = 0; i < DR_C; i++) begin
        check("drain_finish", 32'(finish), 32'd0);
        if (abort_drain && i == 1) begin
          rst = 1'b0;
          #1;
          check_reset_outputs();
          return;
        end
        drive_noise();
        @(negedge ck);
      end
      exp_cnt = r + DR_C;
    end

    exp_pass = (outcome == 1) && pass_val;
    exp_fc   = (outcome == 1) ? (pass_val ? 0 : 1) : outcome;

    check("end_finish", 32'(finish), 32'd1);
    check("end_pass", 32'(pass), 32'(exp_pass));
    check("end_fc", 32'(fail_code), 32'(exp_fc));
    check("end_cnt", cycle_cnt, 32'(exp_cnt));
    check("end_state", 32'(state), exp_pass ? 32'(ST_PASS) : 32'(ST_FAIL));

    // Terminal state must ignore everything until reset.
    for (int i = 0; i < 4; i++) begin
      drive_noise();
      @(negedge ck);
    end
    check("hold_finish", 32'(finish), 32'd1);
    check("hold_fc", 32'(fail_code), 32'(exp_fc));
    check("hold_cnt", cycle_cnt, 32'(exp_cnt));
    check("hold_pass", 32'(pass), 32'(exp_pass));
  endtask

  initial begin
    @(negedge ck);
    run_scn("pass_at20",       20, 1'b1, 1, 5, 1'b0);
    run_scn("dutfail_at7",      7, 1'b0, 1, 5, 1'b0);
    run_scn("timeout",         -1, 1'b0, 1, 3, 1'b0);
    run_scn("stall",           -1, 1'b0, 2, 2, 1'b0);
    run_scn("done_beats_all",  99, 1'b1, 3, 89, 1'b0);
    run_scn("done_beats_fail", 99, 1'b0, 3, 89, 1'b0);
    run_scn("abort_drain",     20, 1'b1, 1, 5, 1'b1);
    run_scn("after_abort",     20, 1'b1, 1, 5, 1'b0);
    run_scn("done_at0",         0, 1'b1, 1, 5, 1'b0);

    for (int k = 0; k < 12; k++) begin
      int da;
      da = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 110));
      run_scn($sformatf("rand%0d", k), da, 1'($urandom), 0,
              int'($urandom_range(70, 98)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Parameters
REQ-001 SHALL have parameter RST_CYCLES, default 8: DUT reset hold length in cycles, range 1 or more.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: run-phase cycle budget, range 1 or more.
REQ-003 SHALL have parameter STALL_CYCLES, default 1000: maximum run cycles without progress; 0 disables the stall check.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 4: cycles between dut_done and the final verdict, range 0 or more.

Interface
REQ-005 SHALL have port: ck  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: dut_rst  out  1  synchronous active-high reset driven to the DUT.
REQ-008 SHALL have port: dut_done  in  1  DUT signals completion, sampled in RUN only.
REQ-009 SHALL have port: dut_pass  in  1  DUT verdict, valid in the dut_done cycle.
REQ-010 SHALL have port: progress  in  1  heartbeat pulse that restarts the stall count.
REQ-011 SHALL have port: cycle_cnt  out  32  RUN plus DRAIN cycle count, saturating at 0xFFFF_FFFF.
REQ-012 SHALL have port: finish  out  1  sticky end-of-run flag.
REQ-013 SHALL have port: pass  out  1  sticky; meaningful only when finish is 1.
REQ-014 SHALL have port: fail_code  out  2  NONE=0, DUT=1, TIMEOUT=2, STALL=3.
REQ-015 SHALL have port: state  out  3  current FSM state, for debug.

Function
REQ-016 SHALL implement FSM states RST_HOLD, RUN, DRAIN, PASS, FAIL; PASS and FAIL are terminal until reset.
REQ-017 RST_HOLD SHALL drive dut_rst=1 for exactly RST_CYCLES cycles, then enter RUN; dut_rst SHALL be 0 from the first RUN cycle.
REQ-018 RUN SHALL increment cycle_cnt once per cycle, and DRAIN SHALL also increment it.
REQ-019 RUN SHALL increment the stall counter each cycle; progress=1 SHALL clear it to 0 in that cycle.
REQ-020 In RUN, dut_done=1 SHALL latch dut_pass and enter DRAIN.
REQ-021 In RUN, with no dut_done, reaching cycle_cnt == TIMEOUT_CYCLES SHALL enter FAIL with fail_code TIMEOUT.
REQ-022 In RUN, with no dut_done and no timeout, reaching stall count == STALL_CYCLES (when STALL_CYCLES > 0) SHALL enter FAIL with fail_code STALL.
REQ-023 Same-cycle priority SHALL be dut_done, then timeout, then stall.
REQ-024 DRAIN SHALL last DRAIN_CYCLES cycles; DRAIN_CYCLES=0 SHALL skip directly to the verdict.
REQ-025 After DRAIN, latched pass=1 SHALL enter PASS, else FAIL with fail_code DUT.
REQ-026 On entering PASS or FAIL, finish SHALL assert and hold; pass, fail_code and cycle_cnt SHALL freeze.
REQ-027 dut_done and progress SHALL be ignored outside RUN; timeout and stall SHALL not be evaluated in DRAIN.
REQ-028 The 32-bit cycle_cnt SHALL saturate rather than wrap.

Reset
REQ-029 rst=0 SHALL asynchronously force: state RST_HOLD, dut_rst=1, cycle_cnt=0, stall count 0, finish=0, pass=0, fail_code NONE.
REQ-030 Reset asserted mid-RUN or mid-DRAIN SHALL discard all progress; on release the full RST_HOLD sequence SHALL restart.

Structure
REQ-031 Package run_ctrl_pkg SHALL hold the state enum, the fail_code enum and the 32-bit count width constant.
REQ-032 A single sub-module run_ctr SHALL provide a clearable, enabled, saturating counter, instanced for phase, cycle and stall counting.

Verification (RST_CYCLES=4, TIMEOUT_CYCLES=100, STALL_CYCLES=10, DRAIN_CYCLES=3)
REQ-033 Reset release, progress every 5 cycles, dut_done with dut_pass=1 at RUN cycle 20 -> dut_rst high exactly 4 cycles, PASS, finish=1, fail_code=0, cycle_cnt=24.
REQ-034 dut_done with dut_pass=0 at RUN cycle 7 -> FAIL, fail_code=1, cycle_cnt=11.
REQ-035 progress every 3 cycles, no dut_done -> FAIL, fail_code=2, cycle_cnt=100.
REQ-036 progress only at RUN cycle 2 -> FAIL, fail_code=3 at stall count 10.
REQ-037 dut_done arriving in the same cycle as both timeout and stall -> DRAIN entered, no TIMEOUT or STALL code reported.
REQ-038 rst pulsed low during DRAIN -> outputs reset immediately; fresh 4-cycle dut_rst; finish=0 until the new verdict.
